// File: rtl/hsst_fifo_pkt_reader.sv
// hsst_fifo_pkt_reader
// Drains the read side of the prefetch (first-word-fall-through) HSST FIFO
// and frames the words into fixed-length packets for the HSST TX lane.
// The framing inserts K-coded IDLE, SOP, FILL and EOP control words.
// Packet layout: SOP, HDR {seq, len}, PKT_LEN payload words, [CSUM], EOP.
//
// Optional feature macro: HSST_PKT_CSUM_EN
//   defined   -> an XOR checksum word is sent between the payload and EOP
//   undefined -> no checksum state or register; the payload goes straight to EOP
//
// Ports (all in the rd_clk domain; rd_rst is async, active-high):
//   link_rdy      in   TX lane ready; while low only IDLE is sent
//   fifo_rd_data  in   FIFO head word (valid with fifo_rd_vld)
//   fifo_rd_vld   in   FIFO head word valid
//   fifo_rd_en    out  pop request (a pop is fifo_rd_vld & fifo_rd_en)
//   tx_data/tx_k  out  registered TX word and per-byte K flags (bit0 = byte0)
//   busy          out  high outside S_IDLE
//   seq_num       out  sequence number of the next packet (wraps)
//   underrun_cnt  out  saturating count of FILL words inserted
//   abort_cnt     out  saturating count of packets aborted by link loss
module hsst_fifo_pkt_reader #(
  parameter int unsigned PKT_LEN = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             link_rdy,
  input  logic [31:0]      fifo_rd_data,
  input  logic             fifo_rd_vld,
  output logic             fifo_rd_en,
  output logic [31:0]      tx_data,
  output logic [3:0]       tx_k,
  output logic             busy,
  output logic [CNT_W-1:0] seq_num,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  localparam logic [31:0] IDLE_D = 32'h50BC_50BC;
  localparam logic [31:0] SOP_D  = 32'h0000_00FB;
  localparam logic [31:0] FILL_D = 32'h0000_001C;
  localparam logic [31:0] EOP_D  = 32'h0000_00FD;
  localparam logic [3:0]  K_IDLE = 4'b0101;
  localparam logic [3:0]  K_CTL  = 4'b0001;
  localparam logic [3:0]  K_DAT  = 4'b0000;
  localparam logic [15:0] LEN16  = 16'(PKT_LEN);
  localparam logic [15:0] LAST   = 16'(PKT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_HDR,
    S_PAY,
`ifdef HSST_PKT_CSUM_EN
    S_CSUM,
`endif
    S_EOP
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pay_cnt, pay_cnt_nxt;
  logic [31:0] data_nxt;
  logic [3:0]  k_nxt;
  logic        seq_inc, und_inc, abort_inc;
  logic [15:0] seq16;

`ifdef HSST_PKT_CSUM_EN
  logic [31:0] csum, csum_nxt;
`endif

  // Header sequence field is 16 bits wide regardless of CNT_W.
  assign seq16 = 16'(seq_num);
  assign busy  = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    pay_cnt_nxt = pay_cnt;
    data_nxt    = IDLE_D;
    k_nxt       = K_IDLE;
    seq_inc     = 1'b0;
    und_inc     = 1'b0;
    abort_inc   = 1'b0;
    fifo_rd_en  = 1'b0;
`ifdef HSST_PKT_CSUM_EN
    csum_nxt    = csum;
`endif
    if (state != S_IDLE && !link_rdy) begin
      // Link loss mid-packet: drop the frame, already-popped words are lost.
      state_nxt = S_IDLE;
      abort_inc = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (link_rdy && fifo_rd_vld) state_nxt = S_SOP;
        end
        S_SOP: begin
          data_nxt  = SOP_D;
          k_nxt     = K_CTL;
          state_nxt = S_HDR;
        end
        S_HDR: begin
          data_nxt    = {seq16, LEN16};
          k_nxt       = K_DAT;
          pay_cnt_nxt = '0;
`ifdef HSST_PKT_CSUM_EN
          csum_nxt    = '0;
`endif
          state_nxt   = S_PAY;
        end
        S_PAY: begin
          fifo_rd_en = link_rdy & fifo_rd_vld;
          if (fifo_rd_vld) begin
            data_nxt    = fifo_rd_data;
            k_nxt       = K_DAT;
            pay_cnt_nxt = pay_cnt + 16'd1;
`ifdef HSST_PKT_CSUM_EN
            csum_nxt    = csum ^ fifo_rd_data;
            if (pay_cnt == LAST) state_nxt = S_CSUM;
`else
            if (pay_cnt == LAST) state_nxt = S_EOP;
`endif
          end else begin
            data_nxt = FILL_D;
            k_nxt    = K_CTL;
            und_inc  = 1'b1;
          end
        end
`ifdef HSST_PKT_CSUM_EN
        S_CSUM: begin
          data_nxt  = csum;
          k_nxt     = K_DAT;
          state_nxt = S_EOP;
        end
`endif
        S_EOP: begin
          data_nxt  = EOP_D;
          k_nxt     = K_CTL;
          seq_inc   = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state        <= S_IDLE;
      pay_cnt      <= '0;
      tx_data      <= IDLE_D;
      tx_k         <= K_IDLE;
      seq_num      <= '0;
      underrun_cnt <= '0;
      abort_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      pay_cnt <= pay_cnt_nxt;
      tx_data <= data_nxt;
      tx_k    <= k_nxt;
      if (seq_inc) seq_num <= seq_num + CNT_W'(1);
      if (und_inc && underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
      if (abort_inc && abort_cnt != '1) abort_cnt <= abort_cnt + CNT_W'(1);
    end
  end

`ifdef HSST_PKT_CSUM_EN
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) csum <= '0;
    else        csum <= csum_nxt;
  end
`endif

endmodule
